regs_wb_sched: RTL and testbench

- Writeback scheduler and scoreboard for the 64x64-bit CPU register file.
- Shares the register file's single write port between NUM_SRC writeback sources (ALU, load unit, CSR/mul) using round-robin valid/ready arbitration.
- Tracks a busy bit per register and generates the decode stall that freezes register-file reads.
- Sits between the issue/decode stage, the execution units and the register file.

---
 rtl/regs_wb_sched_pkg.sv | 16 +
 rtl/regs_wb_sched_if.sv | 30 +++
 rtl/regs_wb_sched_rr_arbiter.sv | 48 ++++
 rtl/regs_wb_sched.sv | 121 ++++++++++++
 tb/tb_regs_wb_sched.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regs_wb_sched_pkg.sv
// Shared CPU constants and types used by the writeback scheduler and its bench.
package regs_wb_sched_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int XLEN       = 64;
  localparam int NUM_REGS   = 64;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // Writeback requester slots on the shared register-file write port.
  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_CSR = 2;

endpackage

// File: rtl/regs_wb_sched_if.sv
// Writeback request bus between the execution units and the scheduler.
// Each source owns one lane of the packed rd/value vectors.
interface regs_wb_sched_if #(
  parameter int NUM_SRC    = 3,
  parameter int REG_ADDR_W = regs_wb_sched_pkg::REG_ADDR_W,
  parameter int XLEN       = regs_wb_sched_pkg::XLEN
);

  logic [NUM_SRC-1:0]            wb_valid_in;
  logic [NUM_SRC*REG_ADDR_W-1:0] wb_rd_in;
  logic [NUM_SRC*XLEN-1:0]       wb_value_in;
  logic [NUM_SRC-1:0]            wb_ready_out;

  // Execution-unit side: presents results and waits for its ready bit.
  modport master (
    output wb_valid_in,
    output wb_rd_in,
    output wb_value_in,
    input  wb_ready_out
  );

  // Scheduler side: grants one source per cycle.
  modport slave (
    input  wb_valid_in,
    input  wb_rd_in,
    input  wb_value_in,
    output wb_ready_out
  );

endinterface

// File: rtl/regs_wb_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// searching cyclically, and moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [PW-1:0] ptr;
  logic [PW:0]   cand;

  // Cyclic priority search starting at the pointer; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!grant_vld && req[cand[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer advances to the slot after the winner; holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (grant_idx == PW'(N-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regs_wb_sched.sv
// Writeback scheduler and register scoreboard. Shares the register-file
// write port between the writeback sources and raises the decode stall
// for RAW and WAW hazards against in-flight destinations.
module regs_wb_sched #(
  parameter int NUM_SRC    = 3,
  parameter int REG_ADDR_W = regs_wb_sched_pkg::REG_ADDR_W,
  parameter int XLEN       = regs_wb_sched_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] dec_rs1_in,
  input  logic [REG_ADDR_W-1:0] dec_rs2_in,
  input  logic                  dec_rs1_used_in,
  input  logic                  dec_rs2_used_in,
  input  logic                  issue_valid_in,
  input  logic [REG_ADDR_W-1:0] issue_rd_in,
  input  logic                  issue_rd_write_in,
  input  logic                  flush_in,
  output logic                  stall_out,
  regs_wb_sched_if.slave        wb,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  rd_write_out,
  output logic [XLEN-1:0]       rd_value_out,
  output logic [31:0]           stall_cycles_out
);

  import regs_wb_sched_pkg::*;

  localparam int NREG = 1 << REG_ADDR_W;
  localparam int PW   = $clog2(NUM_SRC);

  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    grant;
  logic [PW-1:0]         grant_idx;
  logic                  grant_vld;
  logic [REG_ADDR_W-1:0] rd_sel;
  logic [XLEN-1:0]       val_sel;
  logic                  hazard;
  logic                  issue_fire;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Requests are masked during reset so grant and write outputs drop at once.
  assign req = wb.wb_valid_in & {NUM_SRC{rst_n}};

  rr_arbiter #(.N(NUM_SRC), .PW(PW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign wb.wb_ready_out = grant;

  // Route the granted lane onto the register-file write port; zero when idle.
  always_comb begin
    rd_sel  = '0;
    val_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        rd_sel  = wb.wb_rd_in[i*REG_ADDR_W +: REG_ADDR_W];
        val_sel = wb.wb_value_in[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writebacks are accepted but never reach the register file.
  assign rd_out       = rd_sel;
  assign rd_value_out = val_sel;
  assign rd_write_out = grant_vld && (rd_sel != '0);

  // RAW on either used source plus WAW on the destination, from registered busy.
  always_comb begin
    hazard = (dec_rs1_used_in   && busy[dec_rs1_in]) ||
             (dec_rs2_used_in   && busy[dec_rs2_in]) ||
             (issue_rd_write_in && busy[issue_rd_in]);
    stall_out  = rst_n && issue_valid_in && hazard;
    issue_fire = issue_valid_in && !stall_out;
  end

  // Scoreboard update: commit clears, issue sets (set wins), flush clears all.
  always_comb begin
    busy_nxt = busy;
    if (grant_vld) begin
      busy_nxt[rd_sel] = 1'b0;
    end
    if (issue_fire && issue_rd_write_in && (issue_rd_in != '0)) begin
      busy_nxt[issue_rd_in] = 1'b1;
    end
    if (flush_in) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy bits; the clear lands on the same edge the register file commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Stall cycle counter; survives flush, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_out <= '0;
    end else if (stall_out) begin
      stall_cycles_out <= sat_inc(stall_cycles_out);
    end
  end

endmodule

// File: tb/tb_regs_wb_sched.sv
// Bench for the writeback scheduler: directed table, reset corner and
// randomized traffic against a behavioural scoreboard/arbiter model.
module tb_regs_wb_sched;
  import regs_wb_sched_pkg::*;

  localparam int N  = 3;
  localparam int RW = 6;
  localparam int XW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] rs1, rs2, issue_rd;
  logic          rs1_used, rs2_used, issue_valid, issue_wr, flush;
  logic          stall;
  logic [RW-1:0] rd;
  logic          rd_wr;
  logic [XW-1:0] rd_val;
  logic [31:0]   cnt;

  regs_wb_sched_if #(.NUM_SRC(N), .REG_ADDR_W(RW), .XLEN(XW)) wb_if ();

  regs_wb_sched #(.NUM_SRC(N), .REG_ADDR_W(RW), .XLEN(XW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dec_rs1_in        (rs1),
    .dec_rs2_in        (rs2),
    .dec_rs1_used_in   (rs1_used),
    .dec_rs2_used_in   (rs2_used),
    .issue_valid_in    (issue_valid),
    .issue_rd_in       (issue_rd),
    .issue_rd_write_in (issue_wr),
    .flush_in          (flush),
    .stall_out         (stall),
    .wb                (wb_if.slave),
    .rd_out            (rd),
    .rd_write_out      (rd_wr),
    .rd_value_out      (rd_val),
    .stall_cycles_out  (cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit [63:0]   busy_m;
  int          ptr_m;
  logic [31:0] cnt_m;
  int          e_g;
  logic        e_stall, e_wr;
  logic [N-1:0] e_ready;
  logic [RW-1:0] e_rd;
  logic [XW-1:0] e_val;

  typedef struct {
    logic iv; logic [5:0] ird; logic iw;
    logic [5:0] r1; logic u1; logic [5:0] r2; logic u2;
    logic fl; logic [2:0] v; logic [5:0] d0, d1, d2;
    logic es; logic [2:0] er; logic ew; logic [5:0] erd; logic [31:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [5:0] ird, logic iw,
                              logic [5:0] r1, logic u1, logic [5:0] r2, logic u2,
                              logic fl, logic [2:0] v, logic [5:0] d0, logic [5:0] d1,
                              logic [5:0] d2, logic es, logic [2:0] er, logic ew,
                              logic [5:0] erd, logic [31:0] ecnt);
    vec_t t;
    t.iv = iv; t.ird = ird; t.iw = iw; t.r1 = r1; t.u1 = u1; t.r2 = r2; t.u2 = u2;
    t.fl = fl; t.v = v; t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.es = es; t.er = er; t.ew = ew; t.erd = erd; t.ecnt = ecnt;
    return t;
  endfunction

  function automatic logic [XW-1:0] vfun(int s, logic [5:0] d);
    return 64'h0000_1234 + (64'(s) << 16) + (64'(d) << 32);
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    busy_m = '0;
    ptr_m  = 0;
    cnt_m  = '0;
  endtask

  // Expected outputs from the spec rules applied to the current inputs.
  task automatic model_eval();
    e_g = -1;
    for (int k = 0; k < N; k++) begin
      int s;
      s = (ptr_m + k) % N;
      if (e_g < 0 && wb_if.wb_valid_in[s]) e_g = s;
    end
    e_ready = '0;
    e_rd    = '0;
    e_val   = '0;
    if (e_g >= 0) begin
      e_ready[e_g] = 1'b1;
      e_rd  = wb_if.wb_rd_in[e_g*RW +: RW];
      e_val = wb_if.wb_value_in[e_g*XW +: XW];
    end
    e_wr = (e_g >= 0) && (e_rd != 0);
    e_stall = issue_valid && ((rs1_used && busy_m[rs1]) || (rs2_used && busy_m[rs2]) ||
                              (issue_wr && busy_m[issue_rd]));
  endtask

  task automatic model_commit();
    if (e_g >= 0) begin
      busy_m[e_rd] = 1'b0;
      ptr_m = (e_g + 1) % N;
    end
    if (issue_valid && !e_stall && issue_wr && issue_rd != 0) busy_m[issue_rd] = 1'b1;
    if (flush) busy_m = '0;
    if (e_stall && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
  endtask

  task automatic cmp_model(string tag);
    chk({tag, ".stall"}, stall, e_stall);
    chk({tag, ".ready"}, wb_if.wb_ready_out, e_ready);
    chk({tag, ".wr"},    rd_wr, e_wr);
    chk({tag, ".rd"},    rd, e_rd);
    chk({tag, ".val"},   rd_val, e_val);
    chk({tag, ".cnt"},   cnt, cnt_m);
  endtask

  task automatic step_end();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; issue_rd = '0;
    rs1_used = 0; rs2_used = 0; issue_valid = 0; issue_wr = 0; flush = 0;
    wb_if.wb_valid_in = '0; wb_if.wb_rd_in = '0; wb_if.wb_value_in = '0;
  endtask

  task automatic apply_row(vec_t t);
    issue_valid = t.iv; issue_rd = t.ird; issue_wr = t.iw;
    rs1 = t.r1; rs1_used = t.u1; rs2 = t.r2; rs2_used = t.u2; flush = t.fl;
    wb_if.wb_valid_in = t.v;
    wb_if.wb_rd_in    = {t.d2, t.d1, t.d0};
    wb_if.wb_value_in = {vfun(2, t.d2), vfun(1, t.d1), vfun(0, t.d0)};
  endtask

  logic [N-1:0]  src_v;
  logic [RW-1:0] src_d [N];
  logic [XW-1:0] src_val [N];

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", stall, 0);
    chk("rst.ready", wb_if.wb_ready_out, 0);
    chk("rst.wr", rd_wr, 0);
    chk("rst.rd", rd, 0);
    chk("rst.val", rd_val, 0);
    chk("rst.cnt", cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: RAW, rotation, WAW, x0, flush
    tbl.push_back(mk(1,5,1, 0,0,0,0, 0, 3'b000,0,0,0, 0,3'b000,0,0, 0));
    tbl.push_back(mk(1,0,0, 5,1,0,0, 0, 3'b000,0,0,0, 1,3'b000,0,0, 0));
    tbl.push_back(mk(0,0,0, 5,1,0,0, 0, 3'b001,5,0,0, 0,3'b001,1,5, 1));
    tbl.push_back(mk(1,0,0, 5,1,0,0, 0, 3'b000,0,0,0, 0,3'b000,0,0, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0, 3'b111,1,2,3, 0,3'b010,1,2, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0, 3'b111,1,2,3, 0,3'b100,1,3, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0, 3'b111,1,2,3, 0,3'b001,1,1, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0, 3'b111,1,2,3, 0,3'b010,1,2, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0, 3'b111,1,2,3, 0,3'b100,1,3, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0, 3'b111,1,2,3, 0,3'b001,1,1, 1));
    tbl.push_back(mk(1,7,1, 0,0,0,0, 0, 3'b000,0,0,0, 0,3'b000,0,0, 1));
    tbl.push_back(mk(1,7,1, 0,0,0,0, 0, 3'b000,0,0,0, 1,3'b000,0,0, 1));
    tbl.push_back(mk(1,7,1, 0,0,0,0, 0, 3'b010,0,7,0, 1,3'b010,1,7, 2));
    tbl.push_back(mk(1,7,1, 0,0,0,0, 0, 3'b000,0,0,0, 0,3'b000,0,0, 3));
    tbl.push_back(mk(1,0,0, 7,1,0,0, 0, 3'b000,0,0,0, 1,3'b000,0,0, 3));
    tbl.push_back(mk(1,0,1, 0,1,0,0, 0, 3'b100,0,0,0, 0,3'b100,0,0, 4));
    tbl.push_back(mk(1,0,0, 0,1,0,0, 0, 3'b000,0,0,0, 0,3'b000,0,0, 4));
    tbl.push_back(mk(1,9,1, 0,0,0,0, 1, 3'b000,0,0,0, 0,3'b000,0,0, 4));
    tbl.push_back(mk(1,0,0, 9,1,7,1, 0, 3'b000,0,0,0, 0,3'b000,0,0, 4));
    tbl.push_back(mk(1,4,1, 0,0,0,0, 0, 3'b000,0,0,0, 0,3'b000,0,0, 4));
    tbl.push_back(mk(1,0,0, 4,1,0,0, 1, 3'b000,0,0,0, 1,3'b000,0,0, 4));
    tbl.push_back(mk(1,0,0, 4,1,0,0, 0, 3'b001,4,0,0, 0,3'b001,1,4, 5));

    foreach (tbl[i]) begin
      apply_row(tbl[i]);
      #1;
      model_eval();
      cmp_model($sformatf("row%0d", i));
      chk($sformatf("row%0d.tstall", i), stall, tbl[i].es);
      chk($sformatf("row%0d.tready", i), wb_if.wb_ready_out, tbl[i].er);
      chk($sformatf("row%0d.twr", i), rd_wr, tbl[i].ew);
      chk($sformatf("row%0d.trd", i), rd, tbl[i].erd);
      chk($sformatf("row%0d.tcnt", i), cnt, tbl[i].ecnt);
      step_end();
    end

    // Reset mid-stream with busy[3] set and pointer at 2
    idle_inputs();
    issue_valid = 1; issue_rd = 3; issue_wr = 1;
    wb_if.wb_valid_in = 3'b010;
    wb_if.wb_rd_in = {6'd0, 6'd10, 6'd0};
    wb_if.wb_value_in = {vfun(2,0), vfun(1,10), vfun(0,0)};
    #1;
    model_eval();
    cmp_model("pre_rst");
    step_end();
    idle_inputs();
    issue_valid = 1; rs1 = 3; rs1_used = 1;
    wb_if.wb_valid_in = 3'b111;
    wb_if.wb_rd_in = {6'd3, 6'd2, 6'd1};
    wb_if.wb_value_in = {vfun(2,3), vfun(1,2), vfun(0,1)};
    #1;
    chk("mid.stall_before", stall, 1);
    chk("mid.ready_before", wb_if.wb_ready_out, 3'b100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.stall", stall, 0);
    chk("mid.ready", wb_if.wb_ready_out, 0);
    chk("mid.wr", rd_wr, 0);
    chk("mid.rd", rd, 0);
    chk("mid.val", rd_val, 0);
    chk("mid.cnt", cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_eval();
    chk("post_rst.ready", wb_if.wb_ready_out, 3'b001);
    chk("post_rst.stall", stall, 0);
    cmp_model("post_rst");
    step_end();

    // Randomized traffic; sources hold until granted
    idle_inputs();
    src_v = '0;
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!src_v[s] && $urandom_range(0, 2) == 0) begin
          src_v[s]   = 1'b1;
          src_d[s]   = RW'($urandom_range(0, 15));
          src_val[s] = {$urandom, $urandom};
        end
        wb_if.wb_valid_in[s] = src_v[s];
        wb_if.wb_rd_in[s*RW +: RW] = src_d[s];
        wb_if.wb_value_in[s*XW +: XW] = src_val[s];
      end
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_rd    = RW'($urandom_range(0, 15));
      issue_wr    = ($urandom_range(0, 9) < 7);
      rs1         = RW'($urandom_range(0, 15));
      rs2         = RW'($urandom_range(0, 15));
      rs1_used    = $urandom_range(0, 1) == 1;
      rs2_used    = $urandom_range(0, 1) == 1;
      flush       = ($urandom_range(0, 19) == 0);
      #1;
      model_eval();
      cmp_model($sformatf("rnd%0d", c));
      if (e_g >= 0) src_v[e_g] = 1'b0;
      step_end();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
